// File: rtl/reg_dump.sv
// Streams NUM_REGS register-file entries out over a valid/ready byte port, freezing writers while busy.
// Optional trailing XOR checksum byte is enabled by defining DUMP_CHECKSUM_EN.
module reg_dump #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              freeze,
    output logic              done
);

    if ((NUM_REGS < 1) || (NUM_REGS > (1 << ADDR_W))) begin : g_bad_params
        $error("reg_dump: NUM_REGS must be in 1..2**ADDR_W");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SEND  = 3'd2,
        CKSUM = 3'd3,
        DONE  = 3'd4
    } state_t;

    logic [DATA_W-1:0] cksum_q, cksum_d;

    function automatic logic [DATA_W-1:0] cksum_fold(input logic [DATA_W-1:0] acc,
                                                     input logic [DATA_W-1:0] byte_in);
        return acc ^ byte_in;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        SEND  = 3'd2,
        DONE  = 3'd4
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state and next-output computation; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
        cksum_d    = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    index_d   = '0;
                    rd_addr_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    cksum_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                tx_data_d  = rd_data;
                tx_valid_d = 1'b1;
                state_d    = SEND;
`ifdef DUMP_CHECKSUM_EN
                cksum_d    = cksum_fold(cksum_q, rd_data);
`endif
            end
            SEND: begin
                if (tx_ready) begin
                    if (index_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
                        state_d    = CKSUM;
                        tx_data_d  = cksum_q;
                        tx_valid_d = 1'b1;
`else
                        state_d    = DONE;
`endif
                    end else begin
                        // rd_addr moves with the index so the next READ sees the new address.
                        index_d   = index_q + IDX_ONE;
                        rd_addr_d = index_q + IDX_ONE;
                        state_d   = READ;
                    end
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CKSUM: begin
                if (tx_ready) begin
                    state_d = DONE;
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers, cleared asynchronously so a mid-dump reset drops the transfer at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            index_q    <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DUMP_CHECKSUM_EN
            cksum_q    <= cksum_d;
`endif
        end
    end

    assign rd_addr  = rd_addr_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign freeze   = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Directed, table-driven bench for reg_dump: dumps, stalls, ignored restarts and mid-dump reset.
module tb_reg_dump;

`ifdef DUMP_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       freeze;
    logic       done;

    logic [7:0] regs [8];
    assign rd_data = regs[rd_addr];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_dump #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .freeze(freeze), .done(done)
    );

    typedef struct {
        string       name;
        logic [63:0] preload;     // byte i of the register file = preload[8*i +: 8]
        int          stall_byte;  // byte number (0-based) to hold off, -1 = none
        int          stall_len;
        bit          toggle;      // tx_ready alternates every cycle
        int          restart_at;  // byte number during which start is re-pulsed, -1 = none
        bit          check_rate;
        logic [7:0]  cksum;       // hand-computed XOR of the eight bytes
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_dump(input vec_t v);
        int   nbytes = 0;
        int   ndone = 0;
        int   last_cyc = 0;
        int   stall_cnt = 0;
        int   after_done = 0;
        bit   restarted = 1'b0;
        bit   rate_ok = 1'b1;
        bit   stall_ok = 1'b1;
        bit   freeze_ok = 1'b1;
        bit   finished = 1'b0;
        logic r;
        logic [7:0] exp_b;
        for (int i = 0; i < 8; i++) regs[i] = v.preload[8*i +: 8];
        tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({v.name, ":busy_after_start"}, {31'd0, busy}, 32'd1);
        chk({v.name, ":valid_in_read"}, {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        chk({v.name, ":first_valid"}, {31'd0, tx_valid}, 32'd1);
        chk({v.name, ":first_byte"}, {24'd0, tx_data}, {24'd0, v.preload[7:0]});
        for (int cyc = 0; cyc < 300; cyc++) begin
            start = 1'b0;
            if (done) ndone++;
            if (ndone == 0 || done) begin
                if (freeze !== 1'b1 || busy !== 1'b1) freeze_ok = 1'b0;
            end else begin
                after_done++;
                if (after_done <= 2)
                    chk({v.name, ":busy_after_done"}, {30'd0, busy, freeze}, 32'd0);
                if (after_done == 2) begin
                    finished = 1'b1;
                    break;
                end
            end
            exp_b = (nbytes < 8) ? v.preload[8*nbytes +: 8] : v.cksum;
            r = 1'b1;
            if (v.toggle) r = cyc[0];
            if (tx_valid && nbytes == v.stall_byte && stall_cnt < v.stall_len) begin
                r = 1'b0;
                stall_cnt++;
                if (tx_valid !== 1'b1 || tx_data !== exp_b) stall_ok = 1'b0;
            end
            if (tx_valid && nbytes == v.restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            tx_ready = r;
            if (tx_valid && r) begin
                if (nbytes < NB) chk($sformatf("%s:byte%0d", v.name, nbytes), {24'd0, tx_data}, {24'd0, exp_b});
                if (nbytes > 0 && (cyc - last_cyc) != 2) rate_ok = 1'b0;
                last_cyc = cyc;
                nbytes++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({v.name, ":finished_in_budget"}, {31'd0, finished}, 32'd1);
        chk({v.name, ":byte_count"}, nbytes, NB);
        chk({v.name, ":done_count"}, ndone, 32'd1);
        chk({v.name, ":freeze_during_dump"}, {31'd0, freeze_ok}, 32'd1);
        chk({v.name, ":rd_addr_hold"}, {29'd0, rd_addr}, 32'd7);
        if (v.check_rate) chk({v.name, ":one_per_2_cycles"}, {31'd0, rate_ok}, 32'd1);
        if (v.stall_byte >= 0) begin
            chk({v.name, ":stall_stable"}, {31'd0, stall_ok}, 32'd1);
            chk({v.name, ":stall_len"}, stall_cnt, v.stall_len);
        end
    endtask

    initial begin
        int  nb;
        bit  idle_ok;
        vecs[0] = '{"seq",     64'h8877_6655_4433_2211, -1, 0, 1'b0, -1, 1'b1, 8'h88};
        vecs[1] = '{"stall",   64'h8877_6655_4433_2211,  2, 5, 1'b0, -1, 1'b0, 8'h88};
        vecs[2] = '{"restart", 64'h8877_6655_4433_2211, -1, 0, 1'b0,  3, 1'b1, 8'h88};
        vecs[3] = '{"ff_tog",  64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 1'b1, -1, 1'b0, 8'h00};

        #1;
        chk("reset:outputs", {28'd0, tx_valid, busy, freeze, done}, 32'd0);
        chk("reset:rd_addr_tx_data", {21'd0, rd_addr, tx_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle:no_spontaneous_start", {30'd0, busy, tx_valid}, 32'd0);

        run_dump(vecs[0]);
        run_dump(vecs[1]);
        run_dump(vecs[2]);

        // Reset while the fifth byte is on the port, then confirm nothing resumes.
        for (int i = 0; i < 8; i++) regs[i] = vecs[0].preload[8*i +: 8];
        tx_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (tx_valid && nb == 4) break;
            if (tx_valid) nb++;
        end
        chk("midreset:reached_byte5", {24'd0, tx_data}, 32'h55);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset:async_clear", {28'd0, tx_valid, busy, freeze, done}, 32'd0);
        chk("midreset:rd_addr_tx_data", {21'd0, rd_addr, tx_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_valid !== 1'b0) idle_ok = 1'b0;
        end
        chk("midreset:stays_idle", {31'd0, idle_ok}, 32'd1);

        run_dump(vecs[0]);
        run_dump(vecs[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
